// File: rtl/stream_video_crop.sv
// stream_video_crop
//   Removes the invalid border a filter kernel leaves around an AXI4-Stream
//   video frame and regenerates tuser (start of frame) and tlast (end of line)
//   for the smaller cropped frame. Pixel position is tracked from the incoming
//   tuser/tlast markers. Kept pixels go through an output register backed by
//   a one-beat skid register. Cropped pixels are consumed and discarded.
//
// Ports
//   clk                  clock, everything on the rising edge
//   reset                asynchronous, active-low reset
//   s_axis_video_*       input video stream (tdata/tvalid/tready/tuser/tlast)
//   m_axis_video_*       cropped video stream (tdata/tvalid/tready/tuser/tlast)
//   err_short_line       one-cycle pulse: tlast arrived before the last column
//   err_long_line        one-cycle pulse: last column arrived without tlast
module stream_video_crop #(
  parameter int DATA_WIDTH   = 24,
  parameter int FRAME_WIDTH  = 20,
  parameter int FRAME_HEIGHT = 10,
  parameter int CROP_LEFT    = 2,
  parameter int CROP_RIGHT   = 2,
  parameter int CROP_TOP     = 2,
  parameter int CROP_BOTTOM  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
  input  logic                  s_axis_video_tvalid,
  output logic                  s_axis_video_tready,
  input  logic                  s_axis_video_tuser,
  input  logic                  s_axis_video_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  err_short_line,
  output logic                  err_long_line
);

  if (CROP_LEFT + CROP_RIGHT >= FRAME_WIDTH) begin : g_bad_width
    $error("stream_video_crop: CROP_LEFT+CROP_RIGHT must be below FRAME_WIDTH");
  end
  if (CROP_TOP + CROP_BOTTOM >= FRAME_HEIGHT) begin : g_bad_height
    $error("stream_video_crop: CROP_TOP+CROP_BOTTOM must be below FRAME_HEIGHT");
  end

  localparam int XW = $clog2(FRAME_WIDTH + 1);
  localparam int YW = $clog2(FRAME_HEIGHT + 1);
  localparam int PW = DATA_WIDTH + 2;

  localparam logic [XW-1:0] X_FIRST = XW'(CROP_LEFT);
  localparam logic [XW-1:0] X_LAST  = XW'(FRAME_WIDTH - CROP_RIGHT - 1);
  localparam logic [XW-1:0] X_END   = XW'(FRAME_WIDTH - 1);
  localparam logic [XW-1:0] X_SAT   = XW'(FRAME_WIDTH);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_FIRST = YW'(CROP_TOP);
  localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_HEIGHT - CROP_BOTTOM - 1);
  localparam logic [YW-1:0] Y_SAT   = YW'(FRAME_HEIGHT);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          synced;

  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          sync_eff;
  logic          accept;
  logic          keep;
  logic [PW-1:0] in_beat;

  logic [PW-1:0] out_beat;
  logic          out_valid;
  logic [PW-1:0] skid_beat;
  logic          skid_valid;
  logic          skid_valid_next;
  logic          out_ready;

  // A tuser beat restarts the position at the origin and counts as synced
  // for its own keep decision, so the first pixel of a frame is never lost.
  assign cx       = s_axis_video_tuser ? '0 : x;
  assign cy       = s_axis_video_tuser ? '0 : y;
  assign sync_eff = synced | s_axis_video_tuser;
  assign accept   = s_axis_video_tvalid & s_axis_video_tready;

  // Saturated counters (x==FRAME_WIDTH, y==FRAME_HEIGHT) fall outside the
  // window, which is what drops over-long lines and lines past frame end.
  assign keep = accept & sync_eff &
                (cx >= X_FIRST) & (cx <= X_LAST) &
                (cy >= Y_FIRST) & (cy <= Y_LAST);

  assign in_beat = {(cx == X_FIRST) && (cy == Y_FIRST), cx == X_LAST, s_axis_video_tdata};

  // Position tracking and frame synchronisation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x      <= '0;
      y      <= '0;
      synced <= 1'b0;
    end else if (accept) begin
      synced <= sync_eff;
      if (s_axis_video_tlast) begin
        x <= '0;
        y <= (cy == Y_SAT) ? Y_SAT : cy + Y_ONE;
      end else begin
        x <= (cx == X_SAT) ? X_SAT : cx + X_ONE;
        y <= cy;
      end
    end
  end

  // Line-length error pulses. A saturated x is neither below nor equal to
  // the last column, so an overlong line reports only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_short_line <= 1'b0;
      err_long_line  <= 1'b0;
    end else begin
      err_short_line <= accept & sync_eff & s_axis_video_tlast & (cx < X_END);
      err_long_line  <= accept & sync_eff & !s_axis_video_tlast & (cx == X_END);
    end
  end

  // The skid can only be occupied while s_tready is low, so a kept beat never
  // arrives while the skid is full.
  assign out_ready = !out_valid | m_axis_video_tready;

  always_comb begin
    skid_valid_next = skid_valid;
    if (out_ready)
      skid_valid_next = 1'b0;
    else if (keep)
      skid_valid_next = 1'b1;
  end

  // Output register refills from the skid first to preserve beat order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_beat            <= '0;
      out_valid           <= 1'b0;
      skid_beat           <= '0;
      skid_valid          <= 1'b0;
      s_axis_video_tready <= 1'b0;
    end else begin
      if (out_ready) begin
        if (skid_valid) begin
          out_beat  <= skid_beat;
          out_valid <= 1'b1;
        end else if (keep) begin
          out_beat  <= in_beat;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (keep) begin
        skid_beat <= in_beat;
      end
      skid_valid          <= skid_valid_next;
      s_axis_video_tready <= !skid_valid_next;
    end
  end

  assign m_axis_video_tvalid = out_valid;
  assign m_axis_video_tuser  = out_beat[PW-1];
  assign m_axis_video_tlast  = out_beat[PW-2];
  assign m_axis_video_tdata  = out_beat[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_stream_video_crop.sv
// tb_stream_video_crop
//   Directed bench for stream_video_crop with default parameters (20x10 in,
//   16x6 out). Pixel data encodes {frame, row, column} so every output beat
//   identifies its source position. Expected beats are queued as pixels are
//   sent, using the intended source position of each pixel.
module tb_stream_video_crop;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tuser = 1'b0;
  logic        s_tlast = 1'b0;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tuser;
  logic        m_tlast;
  logic        err_short_line;
  logic        err_long_line;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int short_cnt = 0;
  int long_cnt = 0;

  logic [25:0] exp_q[$];
  logic [25:0] got_q[$];

  logic        pv = 1'b0;
  logic [25:0] pbeat = '0;
  logic        stall_prev = 1'b0;
  logic [26:0] prev_bundle = '0;

  always #5 clk = ~clk;

  stream_video_crop dut (
    .clk                 (clk),
    .reset               (reset),
    .s_axis_video_tdata  (s_tdata),
    .s_axis_video_tvalid (s_tvalid),
    .s_axis_video_tready (s_tready),
    .s_axis_video_tuser  (s_tuser),
    .s_axis_video_tlast  (s_tlast),
    .m_axis_video_tdata  (m_tdata),
    .m_axis_video_tvalid (m_tvalid),
    .m_axis_video_tready (m_tready),
    .m_axis_video_tuser  (m_tuser),
    .m_axis_video_tlast  (m_tlast),
    .err_short_line      (err_short_line),
    .err_long_line       (err_long_line)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] pix(input int f, input int yy, input int xx);
    return {8'(f), 8'(yy), 8'(xx)};
  endfunction

  // Negedge monitor: verify held outputs across a stall, choose m_tready for
  // the coming edge, note whether that edge transfers a beat, count pulses.
  always @(negedge clk) begin
    if (stall_prev && reset)
      checkOutput("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, prev_bundle);
    if (ready_mode == 1)
      m_tready = 1'($urandom_range(0, 1));
    else
      m_tready = (ready_mode == 0);
    pv          = reset && m_tvalid && m_tready;
    pbeat       = {m_tuser, m_tlast, m_tdata};
    stall_prev  = reset && m_tvalid && !m_tready;
    prev_bundle = {m_tvalid, m_tuser, m_tlast, m_tdata};
    if (err_short_line) short_cnt++;
    if (err_long_line) long_cnt++;
  end

  // Record the beat transferred at this edge unless reset cut it off.
  always @(posedge clk) begin
    if (pv && reset) got_q.push_back(pbeat);
  end

  task automatic applyStimulus(input logic [23:0] d, input logic u, input logic l);
    int waited = 0;
    @(negedge clk);
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 1000) checkOutput("s_tready_timeout", 64'(s_tready), 64'd1);
    @(posedge clk);
  endtask

  task automatic goIdle();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic sendPixel(input int f, input int yy, input int xx, input logic l, input bit expect_out);
    logic [23:0] d;
    d = pix(f, yy, xx);
    if (expect_out && xx >= 2 && xx < 18 && yy >= 2 && yy < 8)
      exp_q.push_back({(xx == 2 && yy == 2), (xx == 17), d});
    applyStimulus(d, (xx == 0 && yy == 0), l);
  endtask

  // Full frame; short_row ends early at column 15, long_row runs to column 23.
  task automatic sendFrame(input int f, input int short_row, input int long_row);
    for (int yy = 0; yy < 10; yy++) begin
      int len;
      len = (yy == short_row) ? 16 : (yy == long_row) ? 24 : 20;
      for (int xx = 0; xx < len; xx++)
        sendPixel(f, yy, xx, (xx == len - 1), 1'b1);
    end
    goIdle();
  endtask

  task automatic checkFrame(input string tag);
    int n = 0;
    int m;
    while (got_q.size() < exp_q.size() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checkOutput({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      checkOutput($sformatf("%s beat %0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic checkErrors(input string tag, input int exp_short, input int exp_long);
    checkOutput({tag, " short pulses"}, 64'(short_cnt), 64'(exp_short));
    checkOutput({tag, " long pulses"}, 64'(long_cnt), 64'(exp_long));
    short_cnt = 0;
    long_cnt  = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state: every output low, including s_tready.
    repeat (2) @(negedge clk);
    checkOutput("reset outputs",
                {m_tvalid, m_tuser, m_tlast, m_tdata, s_tready, err_short_line, err_long_line}, 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("tready before first edge", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1 checkOutput("tready after first edge", 64'(s_tready), 64'd1);

    $display("[TB] clean frame, m_tready high");
    ready_mode = 0;
    sendFrame(1, -1, -1);
    checkFrame("frame1");
    checkErrors("frame1", 0, 0);

    $display("[TB] clean frame, random m_tready");
    ready_mode = 1;
    sendFrame(2, -1, -1);
    checkFrame("frame2");
    checkErrors("frame2", 0, 0);
    ready_mode = 0;

    $display("[TB] short line 3");
    sendFrame(3, 3, -1);
    checkFrame("short");
    checkErrors("short", 1, 0);

    $display("[TB] long line 5");
    sendFrame(4, -1, 5);
    checkFrame("long");
    checkErrors("long", 0, 1);

    $display("[TB] reset mid-frame");
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < 20; xx++)
        sendPixel(5, yy, xx, (xx == 19), 1'b1);
    for (int xx = 0; xx < 4; xx++)
      sendPixel(5, 2, xx, 1'b0, 1'b1);
    goIdle();
    checkFrame("partial");
    ready_mode = 2;
    sendPixel(5, 2, 4, 1'b0, 1'b0);
    sendPixel(5, 2, 5, 1'b0, 1'b0);
    goIdle();
    @(negedge clk);
    checkOutput("stalled tvalid", 64'(m_tvalid), 64'd1);
    checkOutput("stalled tready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("in-reset outputs %0d", i),
                  {m_tvalid, m_tuser, m_tlast, m_tdata, s_tready, err_short_line, err_long_line}, 64'd0);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    ready_mode = 0;

    $display("[TB] unsynced stream, then frame");
    for (int i = 0; i < 37; i++)
      sendPixel(6, 4, (3 + i) % 20, ((3 + i) % 20 == 19), 1'b0);
    goIdle();
    repeat (20) @(negedge clk);
    checkOutput("unsynced beats out", 64'(got_q.size()), 64'd0);
    checkErrors("unsynced", 0, 0);
    sendFrame(7, -1, -1);
    checkFrame("resync");
    checkErrors("resync", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
